// File: rtl/shift_ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_ex_issue_stage
// Purpose  : Issue stage in front of the ALU/shifter. Captures a decoded
//            bundle, selects operand B (immediate or rs2), and presents a
//            registered bundle to execute. A two-entry main/skid buffer lets
//            in_ready be a pure register, so a full cycle of back-pressure
//            can be absorbed while throughput stays at one bundle per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock (rising edge) / async active-low reset
//   flush               : synchronous kill of both buffered entries
//   in_valid/in_ready   : upstream handshake (in_ready = skid empty)
//   in_alu_op           : operation select
//   in_rs1/rs2_addr     : source register indices (used for forwarding)
//   in_rs1/rs2_data     : register-file read data
//   in_imm, in_use_imm  : immediate and operand-B select
//   in_rd               : destination index, 0 = no writeback
//   out_valid/out_ready : downstream handshake
//   out_alu_op, out_op_a, out_op_b, out_rd : registered issued bundle
//   out_shamt           : out_op_b[5:0], fed straight to the shifter
//   fwd_we/fwd_rd/fwd_data : EX/MEM forwarding source (optional)
// Configuration
//   SHIFT_EX_FWD_EN     : when defined, adds the fwd_* ports and operand
//                         forwarding at capture time.
// ============================================================================
module shift_ex_issue_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_op,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_rd,
  output logic [5:0]      out_shamt
`ifdef SHIFT_EX_FWD_EN
  ,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data
`endif
);

  // Main entry (drives out_*)
  logic            r_main_valid;
  logic [3:0]      r_main_op;
  logic [XLEN-1:0] r_main_a;
  logic [XLEN-1:0] r_main_b;
  logic [4:0]      r_main_rd;

  // Skid entry (holds the bundle accepted while main was stalled)
  logic            r_skid_valid;
  logic [3:0]      r_skid_op;
  logic [XLEN-1:0] r_skid_a;
  logic [XLEN-1:0] r_skid_b;
  logic [4:0]      r_skid_rd;

  logic            w_in_fire;
  logic            w_out_fire;
  logic [XLEN-1:0] w_cap_a;
  logic [XLEN-1:0] w_cap_b;

  assign w_in_fire  = in_valid && !r_skid_valid;
  assign w_out_fire = r_main_valid && out_ready;

`ifdef SHIFT_EX_FWD_EN
  logic w_fwd_a;
  logic w_fwd_b;
  // x0 is never a real producer, so fwd_rd == 0 never forwards.
  assign w_fwd_a = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == in_rs1_addr);
  assign w_fwd_b = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == in_rs2_addr) && !in_use_imm;
  assign w_cap_a = w_fwd_a ? fwd_data : in_rs1_data;
  assign w_cap_b = in_use_imm ? in_imm : (w_fwd_b ? fwd_data : in_rs2_data);
`else
  // Register indices only matter for forwarding.
  logic w_unused_addr;
  assign w_unused_addr = ^{in_rs1_addr, in_rs2_addr};
  assign w_cap_a = in_rs1_data;
  assign w_cap_b = in_use_imm ? in_imm : in_rs2_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_op    <= '0;
      r_main_a     <= '0;
      r_main_b     <= '0;
      r_main_rd    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_op    <= '0;
      r_skid_a     <= '0;
      r_skid_b     <= '0;
      r_skid_rd    <= '0;
    end else if (flush) begin
      // Payload registers keep their values so the datapath does not toggle.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (!r_main_valid || w_out_fire) begin
        // Main is free this edge. The skid entry is older than anything on
        // the input (and in_ready is low while it is occupied), so it wins.
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_op    <= r_skid_op;
          r_main_a     <= r_skid_a;
          r_main_b     <= r_skid_b;
          r_main_rd    <= r_skid_rd;
          r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_op    <= in_alu_op;
          r_main_a     <= w_cap_a;
          r_main_b     <= w_cap_b;
          r_main_rd    <= in_rd;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        // Main is stalled: park the new bundle in the skid entry.
        r_skid_valid <= 1'b1;
        r_skid_op    <= in_alu_op;
        r_skid_a     <= w_cap_a;
        r_skid_b     <= w_cap_b;
        r_skid_rd    <= in_rd;
      end
    end
  end

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_alu_op = r_main_op;
  assign out_op_a   = r_main_a;
  assign out_op_b   = r_main_b;
  assign out_rd     = r_main_rd;
  // Only the low six bits matter to a 64-bit shifter; no saturation.
  assign out_shamt  = r_main_b[5:0];

endmodule
`default_nettype wire

// File: tb/tb_shift_ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_ex_issue_stage
// Purpose  : Self-checking bench for shift_ex_issue_stage: table vectors,
//            directed stall/flush/reset sequences, and randomized traffic
//            compared against a two-deep FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_ex_issue_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_alu_op;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_op_a;
  logic [XLEN-1:0] out_op_b;
  logic [4:0]      out_rd;
  logic [5:0]      out_shamt;
  logic            fwd_we;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  shift_ex_issue_stage #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_rs1_addr(in_rs1_addr),
    .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_op_a   (out_op_a),
    .out_op_b   (out_op_b),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt)
`ifdef SHIFT_EX_FWD_EN
    ,
    .fwd_we     (fwd_we),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
  } bundle_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [5:0]  exp_shamt;
  } vec_t;

  vec_t    vecs[6];
  bundle_t q[$];
  bundle_t m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [63:0] imm,
                        input logic use_imm, input logic [4:0] rd);
    in_valid    = v;
    in_alu_op   = op;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_imm      = imm;
    in_use_imm  = use_imm;
    in_rd       = rd;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    in_rs1_addr = 5'd1;
    in_rs2_addr = 5'd2;
    fwd_we      = 1'b0;
    fwd_rd      = 5'd0;
    fwd_data    = '0;
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: what the stage would capture from the current inputs.
  function automatic bundle_t ref_capture();
    bundle_t r;
    r.op = in_alu_op;
    r.rd = in_rd;
    r.a  = in_rs1_data;
    r.b  = in_use_imm ? in_imm : in_rs2_data;
`ifdef SHIFT_EX_FWD_EN
    if (fwd_we && fwd_rd != 0 && fwd_rd == in_rs1_addr) r.a = fwd_data;
    if (!in_use_imm && fwd_we && fwd_rd != 0 && fwd_rd == in_rs2_addr) r.b = fwd_data;
`endif
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'h1, 64'd17, 64'hDEAD, 64'd8,    1'b1, 5'd3,  64'd17, 64'd8,    6'd8};
    vecs[1] = '{4'h1, 64'd5,  64'd0,    64'h7F,   1'b1, 5'd4,  64'd5,  64'h7F,   6'd63};
    vecs[2] = '{4'h5, 64'd6,  64'd0,    64'h40,   1'b1, 5'd5,  64'd6,  64'h40,   6'd0};
    vecs[3] = '{4'h5, 64'd7,  64'h123,  64'h3,    1'b0, 5'd6,  64'd7,  64'h123,  6'h23};
    vecs[4] = '{4'hD, 64'd9,  64'hFFFF_FFFF_FFFF_FFC5, 64'd1, 1'b0, 5'd0, 64'd9,
                64'hFFFF_FFFF_FFFF_FFC5, 6'd5};
    vecs[5] = '{4'h2, 64'hA5A5, 64'd7,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 64'hA5A5,
                64'hFFFF_FFFF_FFFF_FFFF, 6'd63};

    // ---------------- reset state ----------------
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_op_a", out_op_a, 0);
    chk("reset_shamt", out_shamt, 0);

    // ---------------- table vectors, streaming ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].use_imm, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      chk($sformatf("vec%0d_op", i), out_alu_op, vecs[i].op);
      chk($sformatf("vec%0d_op_a", i), out_op_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_op_b", i), out_op_b, vecs[i].exp_b);
      chk($sformatf("vec%0d_shamt", i), out_shamt, vecs[i].exp_shamt);
      chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_hold_a", out_op_a, 64'hA5A5);
    chk("bubble_hold_b", out_op_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // ---------------- stall: A then B, order preserved ----------------
    out_ready = 1'b0;
    set_in(1'b1, 4'h1, 64'hAAAA, 64'd0, 64'd1, 1'b1, 5'd10);
    @(negedge clk);
    chk("stall_A_valid", out_valid, 1);
    chk("stall_A_in_ready", in_ready, 1);
    set_in(1'b1, 4'h2, 64'hBBBB, 64'd0, 64'd2, 1'b1, 5'd11);
    @(negedge clk);
    chk("stall_B_in_ready", in_ready, 0);
    chk("stall_hold_A", out_op_a, 64'hAAAA);
    // C offered while full must be ignored
    set_in(1'b1, 4'h3, 64'hCCCC, 64'd0, 64'd3, 1'b1, 5'd12);
    @(negedge clk);
    chk("stall_full_in_ready", in_ready, 0);
    chk("stall_still_A", out_op_a, 64'hAAAA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_B_valid", out_valid, 1);
    chk("drain_B_a", out_op_a, 64'hBBBB);
    chk("drain_B_rd", out_rd, 11);
    chk("drain_in_ready", in_ready, 1);
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    // ---------------- flush overrides accept ----------------
    out_ready = 1'b0;
    set_in(1'b1, 4'h1, 64'h1111, 64'd0, 64'd4, 1'b1, 5'd7);
    @(negedge clk);
    set_in(1'b1, 4'h4, 64'hC0C0, 64'd0, 64'd5, 1'b1, 5'd8);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_hold_a", out_op_a, 64'h1111);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush_no_C_%0d", k), out_valid, 0);
    end

    // ---------------- async reset mid-stall ----------------
    out_ready = 1'b0;
    set_in(1'b1, 4'h6, 64'h2222, 64'd0, 64'h3F, 1'b1, 5'd9);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_op", out_alu_op, 0);
    chk("arst_a", out_op_a, 0);
    chk("arst_b", out_op_b, 0);
    chk("arst_shamt", out_shamt, 0);
    chk("arst_rd", out_rd, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 4'h7, 64'h3333, 64'd0, 64'd6, 1'b1, 5'd13);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_a", out_op_a, 64'h3333);
    @(negedge clk);

`ifdef SHIFT_EX_FWD_EN
    // ---------------- forwarding ----------------
    out_ready   = 1'b1;
    in_rs1_addr = 5'd5;
    fwd_we = 1'b1; fwd_rd = 5'd5; fwd_data = 64'd99;
    set_in(1'b1, 4'h1, 64'd11, 64'd22, 64'd3, 1'b1, 5'd1);
    @(negedge clk);
    chk("fwd_a_hit", out_op_a, 64'd99);
    chk("fwd_b_imm", out_op_b, 64'd3);
    in_rs1_addr = 5'd0; fwd_rd = 5'd0;
    @(negedge clk);
    chk("fwd_x0_a", out_op_a, 64'd11);
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd6; fwd_rd = 5'd6; in_use_imm = 1'b0;
    @(negedge clk);
    chk("fwd_b_hit", out_op_b, 64'd99);
    chk("fwd_a_miss", out_op_a, 64'd11);
    in_valid = 1'b0; fwd_we = 1'b0;
    @(negedge clk);
`endif

    // ---------------- randomized traffic vs FIFO model ----------------
    do_reset();
    q.delete();
    m_last = '{4'd0, 64'd0, 64'd0, 5'd0};
    for (int c = 0; c < 500; c++) begin
      bundle_t nb;
      logic    exp_rdy;
      @(negedge clk);
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_op", out_alu_op, m_last.op);
      chk("rnd_a", out_op_a, m_last.a);
      chk("rnd_b", out_op_b, m_last.b);
      chk("rnd_shamt", out_shamt, m_last.b[5:0]);
      chk("rnd_rd", out_rd, m_last.rd);
      if (n_fail > 20) break;

      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 1) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      in_alu_op   = 4'($urandom);
      in_rs1_data = {$urandom, $urandom};
      in_rs2_data = {$urandom, $urandom};
      in_imm      = {$urandom, $urandom};
      in_use_imm  = 1'($urandom);
      in_rd       = 5'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_addr = 5'($urandom_range(0, 7));
      fwd_we      = 1'($urandom);
      fwd_rd      = 5'($urandom_range(0, 7));
      fwd_data    = {$urandom, $urandom};

      nb      = ref_capture();
      exp_rdy = (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(nb);
      end
      if (q.size() > 0) m_last = q[0];
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
